// File: rtl/trig_capture.sv
// Pre-trigger capture engine: records qualified samples into a ring buffer, detects a trigger
// on one channel and dumps the surrounding frame in chronological order to a display write port.
module trig_capture #(
    parameter int ADDR_W    = 10,
    parameter int PRE_DEPTH = 256
) (
    input  logic              iSysClk,
    input  logic              iRst,
    input  logic              clk_en,
    input  logic [7:0]        data_in,
    input  logic              arm,
    input  logic              single_shot,
    input  logic              trigger_en,
    input  logic [2:0]        chn_sel,
    input  logic [2:0]        mode_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              triggered,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   PRE_C   = (ADDR_W + 1)'(PRE_DEPTH);
    localparam logic [ADDR_W:0]   POST_C  = DEPTH_C - PRE_C;
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PRE_PTR = ADDR_W'(PRE_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_ARMED,
        S_POST,
        S_DUMP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        prev_data_q, prev_data_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q;
    logic              acc;
    logic              rd_en;
    logic              cur_bit;
    logic              prev_bit;
    logic              hit;

    logic [7:0] mem [DEPTH];

    // Sampling only happens while the ring is live; dump and idle samples are dropped.
    assign acc = clk_en && (state_q == S_PRE_FILL || state_q == S_ARMED || state_q == S_POST);

    // The whole previous byte is kept so a live chn_sel change still compares the same channel.
    assign cur_bit  = data_in[chn_sel];
    assign prev_bit = prev_data_q[chn_sel];

    always_comb begin
        hit = 1'b0;
        case (mode_sel)
            3'd0:    hit = !prev_bit && cur_bit;
            3'd1:    hit = prev_bit && !cur_bit;
            3'd2:    hit = prev_bit != cur_bit;
            3'd3:    hit = cur_bit;
            3'd4:    hit = !cur_bit;
            default: hit = 1'b1;
        endcase
        if (!trigger_en) begin
            hit = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trig_ptr_d  = trig_ptr_q;
        rptr_d      = rptr_q;
        triggered_d = triggered_q;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wptr_d      = acc ? wptr_q + 1'b1 : wptr_q;
        prev_data_d = acc ? data_in : prev_data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d = S_PRE_FILL;
                    cnt_d   = '0;
                end
            end
            S_PRE_FILL: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == PRE_C) begin
                        state_d = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (acc && hit) begin
                    trig_ptr_d  = wptr_q;
                    triggered_d = 1'b1;
                    cnt_d       = ONE_C;
                    state_d     = S_POST;
                    if (POST_C == ONE_C) begin
                        rptr_d  = wptr_q - PRE_PTR;
                        cnt_d   = '0;
                        state_d = S_DUMP;
                    end
                end
            end
            S_POST: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == POST_C) begin
                        rptr_d  = trig_ptr_q - PRE_PTR;
                        cnt_d   = '0;
                        state_d = S_DUMP;
                    end
                end
            end
            S_DUMP: begin
                if (cnt_q < DEPTH_C) begin
                    rd_en     = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    rptr_d    = rptr_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end else begin
                    // Final write is on the port this cycle; done lands on the next one.
                    done_d      = 1'b1;
                    triggered_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = single_shot ? S_DONE : S_PRE_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (acc) begin
            mem[wptr_q] <= data_in;
        end
    end

    always_ff @(posedge iSysClk or posedge iRst) begin
        if (iRst) begin
            wr_data_q <= '0;
        end else if (rd_en) begin
            wr_data_q <= mem[rptr_q];
        end
    end

    always_ff @(posedge iSysClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            trig_ptr_q  <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            prev_data_q <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            trig_ptr_q  <= trig_ptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            prev_data_q <= prev_data_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_en     = wr_en_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_trig_capture.sv
// Directed bench for trig_capture with DEPTH 16 / PRE_DEPTH 4: free run, edge triggers,
// sparse strobes, ring wrap, auto re-arm and reset during a dump.
module tb_trig_capture;

    localparam int ADDR_W    = 4;
    localparam int PRE_DEPTH = 4;
    localparam int DEPTH     = 16;

    logic              iSysClk = 1'b0;
    logic              iRst = 1'b1;
    logic              clk_en = 1'b0;
    logic [7:0]        data_in = '0;
    logic              arm = 1'b0;
    logic              single_shot = 1'b1;
    logic              trigger_en = 1'b0;
    logic [2:0]        chn_sel = '0;
    logic [2:0]        mode_sel = '0;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              triggered;
    logic              done;

    trig_capture #(.ADDR_W(ADDR_W), .PRE_DEPTH(PRE_DEPTH)) dut (
        .iSysClk(iSysClk), .iRst(iRst), .clk_en(clk_en), .data_in(data_in), .arm(arm),
        .single_shot(single_shot), .trigger_en(trigger_en), .chn_sel(chn_sel),
        .mode_sel(mode_sel), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .busy(busy), .triggered(triggered), .done(done)
    );

    always #5 iSysClk = ~iSysClk;

    int n_checks = 0;
    int n_errors = 0;
    int smp = 0;
    int base = 0;
    int gen_kind = 0;
    int ncyc = 0;
    int nwr = 0;
    int ndone = 0;
    bit trig_seen = 0;
    int cap_a [64];
    int cap_d [64];
    int wcyc [64];

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gen(input int i);
        if (gen_kind == 1) return (i < 40) ? 8'(8'h80 | i) : 8'(i);
        return 8'(base + i);
    endfunction

    always @(negedge iSysClk) begin
        ncyc++;
        if (wr_en) begin
            if (nwr < 64) begin
                cap_a[nwr] = int'(wr_addr);
                cap_d[nwr] = int'(wr_data);
                wcyc[nwr]  = ncyc;
            end
            nwr++;
        end
        if (done) ndone++;
        if (triggered) trig_seen = 1;
    end

    task automatic tick(input bit en);
        clk_en  = en;
        data_in = gen(smp);
        @(posedge iSysClk);
        #1;
        if (en) smp++;
    endtask

    task automatic do_arm();
        nwr = 0;
        trig_seen = 0;
        arm = 1'b1;
        tick(1'b0);
        arm = 1'b0;
    endtask

    task automatic run_until_done(input int per, input string tag);
        bit got;
        got = 0;
        for (int c = 0; c < 400; c++) begin
            tick((c % per) == 0);
            if (done) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, int'(got), 1);
    endtask

    task automatic check_frame(input int first_idx, input string tag);
        chk({tag, "_nwr"}, nwr, DEPTH);
        chk({tag, "_trig_seen"}, int'(trig_seen), 1);
        if (nwr >= DEPTH) begin
            chk({tag, "_burst_len"}, wcyc[DEPTH-1] - wcyc[0], DEPTH - 1);
            for (int i = 0; i < DEPTH; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), cap_a[i], i);
                chk($sformatf("%s_data%0d", tag, i), cap_d[i], int'(gen(first_idx + i)));
            end
        end
    endtask

    initial begin
        int d0;
        int s0;
        int w0;
        bit got;

        // Reset values
        tick(1'b0);
        tick(1'b0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_triggered", int'(triggered), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        iRst = 1'b0;
        tick(1'b0);

        // Free run; arm pulse during POST must be ignored
        gen_kind = 0; base = 0; smp = 0;
        trigger_en = 1'b0; single_shot = 1'b1;
        d0 = ndone;
        do_arm();
        chk("free_busy_after_arm", int'(busy), 1);
        for (int c = 0; c < 8; c++) tick(1'b1);
        chk("free_triggered_in_post", int'(triggered), 1);
        arm = 1'b1;
        tick(1'b1);
        arm = 1'b0;
        run_until_done(1, "free");
        chk("free_triggered_at_done", int'(triggered), 0);
        tick(1'b1);
        tick(1'b1);
        chk("free_busy_after", int'(busy), 0);
        chk("free_done_pulses", ndone - d0, 1);
        check_frame(0, "free");

        // Rising edge on bit 3 from 0: trigger value 8, oldest 4
        base = 0; smp = 0;
        trigger_en = 1'b1; mode_sel = 3'd0; chn_sel = 3'd3;
        do_arm();
        run_until_done(1, "rise0");
        tick(1'b1);
        check_frame(4, "rise0");

        // Bit 3 already high at arming: next 0->1 is value 24, oldest 20
        base = 10; smp = 0;
        do_arm();
        run_until_done(1, "rise10");
        tick(1'b1);
        check_frame(10, "rise10");

        // Sparse strobe, free run: same content, dump still back-to-back
        base = 0; smp = 0;
        trigger_en = 1'b0;
        do_arm();
        run_until_done(3, "sparse");
        tick(1'b1);
        check_frame(0, "sparse");

        // Level low on bit 7 after 40 high samples: ring wraps
        gen_kind = 1; smp = 0;
        trigger_en = 1'b1; mode_sel = 3'd4; chn_sel = 3'd7;
        do_arm();
        run_until_done(1, "wrap");
        tick(1'b1);
        check_frame(36, "wrap");

        // Auto re-arm: strobe held off around done so frame 2 start is unambiguous
        gen_kind = 0; base = 0; smp = 0;
        trigger_en = 1'b0; single_shot = 1'b0;
        do_arm();
        run_until_done(1, "rearm1");
        check_frame(0, "rearm1");
        tick(1'b0);
        tick(1'b0);
        chk("rearm_busy_after_done", int'(busy), 1);
        single_shot = 1'b1;
        s0 = smp;
        nwr = 0;
        trig_seen = 0;
        run_until_done(1, "rearm2");
        tick(1'b1);
        check_frame(s0, "rearm2");
        chk("rearm2_busy_after", int'(busy), 0);

        // Reset in the middle of a dump
        base = 0; smp = 0;
        do_arm();
        got = 0;
        for (int c = 0; c < 200; c++) begin
            tick(1'b1);
            if (nwr >= 5) begin
                got = 1;
                break;
            end
        end
        chk("rstmid_reached_dump", int'(got), 1);
        iRst = 1'b1;
        #1;
        chk("rstmid_wr_en", int'(wr_en), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_triggered", int'(triggered), 0);
        tick(1'b1);
        iRst = 1'b0;
        w0 = nwr;
        d0 = ndone;
        for (int c = 0; c < 30; c++) tick(1'b1);
        chk("rstmid_no_more_writes", nwr - w0, 0);
        chk("rstmid_no_done", ndone - d0, 0);
        chk("rstmid_idle", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trig_capture.md
Name: trig_capture

Overview:
- Pre-trigger capture engine between the clock-enable divider and the waveform display write port.
- Continuously records 8-bit logic-analyser samples into an internal ring buffer, qualified by the divider's sample enable.
- Detects a trigger on a selected channel and keeps PRE_DEPTH samples before it and the remainder after it.
- Dumps the frame in chronological order as a linear write stream (wr_addr/wr_data/wr_en) into the display buffer.

Parameters:
- ADDR_W, 10, log2 of frame depth; DEPTH = 2**ADDR_W samples per frame
- PRE_DEPTH, 256, samples kept before the trigger sample; must satisfy 1 <= PRE_DEPTH <= DEPTH-1

Ports:
- iSysClk  in  1  system clock; single clock domain
- iRst  in  1  asynchronous, active-high reset
- clk_en  in  1  sample strobe from the divider; a sample is taken on each cycle where it is high
- data_in  in  8  logic-analyser input channels, already synchronous to iSysClk
- arm  in  1  one-cycle start pulse
- single_shot  in  1  1 = stop after one frame; 0 = re-arm automatically
- trigger_en  in  1  0 = free-run, trigger on the first armed sample
- chn_sel  in  3  trigger channel index into data_in
- mode_sel  in  3  0 rising, 1 falling, 2 either edge, 3 level high, 4 level low, 5-7 immediate
- wr_addr  out  ADDR_W  display write address
- wr_data  out  8  display write data
- wr_en  out  1  display write strobe
- busy  out  1  high in every state except IDLE and DONE
- triggered  out  1  high from trigger detection until the dump completes
- done  out  1  one-cycle pulse after the last dump write

Behaviour:
- Reset: state IDLE; wr_addr=0, wr_data=0, wr_en=0, busy=0, triggered=0, done=0; ring write pointer wptr=0; counters=0; prev_bit=0.
- Ring buffer: DEPTH x 8 synchronous RAM.
  - Accepted sample written at wptr; wptr increments mod DEPTH.
  - Sample acceptance requires clk_en=1 and state PRE_FILL, ARMED or POST.
  - clk_en is ignored in IDLE, DUMP and DONE; those samples are dropped.
- States:
  - IDLE: arm -> PRE_FILL; clear count.
  - PRE_FILL: accept samples; after PRE_DEPTH accepted -> ARMED. No trigger evaluation.
  - ARMED:
    - Each accepted sample is evaluated; cur = data_in[chn_sel]; prev_bit = channel bit of the previous accepted sample.
    - Rising: prev=0 & cur=1. Falling: prev=1 & cur=0. Either: prev!=cur. High: cur=1. Low: cur=0. Modes 5-7, or trigger_en=0: true.
    - On true: trig_ptr=current wptr; triggered=1; post count=1 (trigger sample counts); -> POST.
    - The ring overwrites the oldest entries while ARMED.
  - POST: accept samples until DEPTH-PRE_DEPTH post samples (including the trigger sample) are stored -> DUMP. rptr = trig_ptr - PRE_DEPTH mod DEPTH.
  - DUMP:
    - Issue one RAM read per cycle, rptr incrementing mod DEPTH, for DEPTH reads.
    - Read latency is 1 cycle; wr_en is high on the cycle after each read, for exactly DEPTH consecutive cycles.
    - wr_addr runs 0..DEPTH-1 and is registered alongside wr_data.
    - wr_addr PRE_DEPTH carries the trigger sample; wr_addr 0 carries the oldest pre sample.
  - End of DUMP: on the cycle after the final write, done=1 for one cycle, triggered=0. Then -> DONE if single_shot=1, else -> PRE_FILL (count cleared).
  - DONE: arm -> PRE_FILL.
- Control changes:
  - arm while busy is ignored.
  - chn_sel, mode_sel and trigger_en are sampled live each evaluation and are not latched.
- Mid-operation reset returns immediately to reset values; partially dumped data is not completed.
- wr_en is never high outside DUMP plus its 1-cycle tail.
- Counters are ADDR_W+1 bits wide so DEPTH is representable.

Test Plan:
- Use ADDR_W=4 (DEPTH 16) and PRE_DEPTH=4. Drive data_in = incrementing counter, clk_en every cycle.
- Free run: trigger_en=0, arm pulse -> 4 pre-fill samples, then the 5th sample triggers. Exactly 16 writes, wr_addr 0..15, wr_data consecutive with wr_data@addr4 = trigger sample; done one pulse; busy=0 after (single_shot=1).
- Rising edge: mode_sel=0, chn_sel=3, data_in counter starting 0.
  - The first rising edge of bit 3 after pre-fill (sample value 8) triggers, giving wr_data@addr4=8 and wr_data@addr0=4.
  - Bit 3 is already high at arming -> no trigger until the next 0->1 transition (value 24).
- Sparse clk_en: assert every 3rd cycle -> dump content identical to the dense case; dump itself still 16 back-to-back wr_en cycles; clk_en during DUMP changes nothing.
- Ring wrap: level-low mode on bit 7 with data held high for 40 samples, then low -> ring wrapped. Output is the 4 samples immediately preceding the trigger plus the trigger and 11 following, correctly ordered across the wrap.
- Auto re-arm / ignore arm: single_shot=0 -> second frame starts pre-fill the cycle after done. Arm pulse during POST ignored. Assert iRst mid-DUMP -> wr_en=0 and busy=0 immediately, state IDLE.
